m_ucode_store: RTL and testbench
================================

# m_ucode_store

Parametrised, runtime-loadable microcode store for midgetv: the successor to the fixed-contents EBR microcode. It holds 2^AW words of DW bits, delivers the registered control word `d` addressed by `minx` with one-cycle latency under `progress_ucode`, and adds a byte-serial loader. The loader lets boot logic or a debug host rewrite the whole microcode after reset. It sits between the instruction decoder (which supplies `minx`) and the control-line fan-out wrapper (which slices `d`).

## Interface
- `AW`, 8, address width; depth is 2^AW words.
- `DW`, 48, microcode word width; must be a multiple of 8, 8..64.
- `NB`, DW/8 (derived, not overridable), bytes per word.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `minx`  in  AW  microcode read address.
- `progress_ucode`  in  1  1 = update `d` from `minx`; 0 = hold (used while shifting).
- `d`  out  DW  registered microcode word.
- `ucode_valid`  out  1  high once a complete load has finished; low during any load.
- `ld_start`  in  1  single-cycle request to begin or restart a load at address 0.
- `ld_valid`  in  1  `ld_data` byte is offered.
- `ld_data`  in  8  load byte; little-endian within a word, word 0 first.
- `ld_ready`  out  1  store accepts a byte this cycle.
- `ld_busy`  out  1  loader not IDLE.
- `ld_done`  out  1  one-cycle pulse after the last word is written.

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset drives `d`=0, `ucode_valid`=0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0, FSM=IDLE, address counter=0, byte counter=0. Reset does not clear memory contents.
- Read path: if FSM=IDLE and `progress_ucode`=1, `d` <= mem[`minx`]. Otherwise `d` holds. Exception: while FSM is not IDLE, `d` is forced to 0 (all-zero word = NOP control).
- Loader FSM has three states:
  - IDLE: `ld_start` -> LOAD. Clears the address counter, clears the byte counter and clears `ucode_valid`.
  - LOAD: `ld_ready`=1. Each byte accepted on `ld_valid & ld_ready` shifts into assembly register bits [8k+7:8k], where k is the byte counter. When k=NB-1 is accepted -> WRITE; otherwise k increments.
  - WRITE: `ld_ready`=0. mem[addr] <= assembled word and k <= 0.
    - If addr = 2^AW-1: -> IDLE, pulse `ld_done`, set `ucode_valid`.
    - Otherwise: addr increments (wraps only via restart) and -> LOAD.
- `ld_busy` = (FSM != IDLE).
- `ld_start` in LOAD or WRITE aborts the load: -> LOAD, addr=0, k=0, and the partial word is discarded. A WRITE in that same cycle is suppressed. `ld_start` has priority over a simultaneous `ld_valid`.
- `ld_valid` outside LOAD is ignored; no byte is consumed.
- A partially loaded memory never raises `ucode_valid`. `ucode_valid` stays 0 until a full, unaborted pass completes.
- Memory is written only in WRITE, one word per write, on a single port. Reads are suppressed while busy, so there is no read/write collision.
- The memory infers EBR for 2^AW·DW ≥ 4 kbit and LUT RAM otherwise. Behaviour is identical either way.

## Timing
- Read latency is 1 cycle: `minx` sampled at edge n appears on `d` after edge n.
- Hold: `progress_ucode`=0 at edge n leaves `d` unchanged after edge n.
- Load throughput is NB cycles + 1 WRITE cycle per word, given back-to-back `ld_valid`. A full load takes at minimum 2^AW·(NB+1) cycles after the cycle in which `ld_start` is sampled.
- `ld_done` and `ucode_valid`=1 are both asserted in the cycle following WRITE of the last word. The first valid read (`d` from new contents) is available one edge after `progress_ucode` is sampled in IDLE.
- Reset mid-load takes effect immediately (asynchronous): outputs return to reset values. Memory holds the words written so far.

## Test plan
- Reset with AW=2, DW=16: deassert `rst_n` mid-cycle -> `d`=0, `ucode_valid`=0, `ld_ready`=0 immediately, without a clock edge.
- Full load with AW=2, DW=16: pulse `ld_start`, then stream bytes 34 12 78 56 BC 9A F0 DE back-to-back. Required: `ld_ready` drops every third cycle, `ld_done` pulses once, `ucode_valid`=1. Then reads with `progress_ucode`=1, `minx`=0,1,2,3 -> `d`=1234,5678,9ABC,DEF0, each one cycle later.
- Hold: with `minx` stepping 0->3 and `progress_ucode`=0 for two cycles -> `d` stays 1234. On release, `d`=DEF0 one cycle later.
- Abort: after 5 bytes, pulse `ld_start` together with `ld_valid` -> that byte is dropped and addr=0. Load 8 new bytes 11 11 22 22 33 33 44 44 -> mem = 1111,2222,3333,4444, with exactly one `ld_done`.
- Busy gating: during a load drive `progress_ucode`=1, `minx`=2 -> `d`=0 and `ucode_valid`=0 throughout. `ld_valid` in IDLE with data FF -> no write and no state change.
- Default parameters AW=8, DW=48: load 256 words where word i = {i repeated over 6 bytes}. Then random `minx` reads -> `d` equals the replicated `minx`. Total load time is 1792 cycles with continuous `ld_valid`.

Source files
------------

// File: rtl/m_ucode_store.sv
// Runtime-loadable microcode store: registered 1-cycle read of mem[minx] plus a
// byte-serial loader that rewrites the whole store, word 0 first, little-endian bytes.
//
// state   | meaning
// S_IDLE  | normal operation, d follows mem[minx] under progress_ucode
// S_LOAD  | accepting bytes into the assembly register, ld_ready=1
// S_WRITE | committing the assembled word to mem[addr]
module m_ucode_store #(
    parameter int AW = 8,
    parameter int DW = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] minx,
    input  logic          progress_ucode,
    output logic [DW-1:0] d,
    output logic          ucode_valid,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done
);

    localparam int NB    = DW / 8;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_addr;
    logic [BW-1:0]        r_byte;
    logic [NB-1:0][7:0]   r_asm;
    logic [DW-1:0]        r_d;
    logic                 r_valid;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [DW-1:0]        r_mem [DEPTH];
    logic                 w_mem_we;

    // A restart in the WRITE cycle discards the word instead of committing it.
    assign w_mem_we = (r_state == S_WRITE) && !ld_start;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_asm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_byte  <= '0;
            r_asm   <= '0;
            r_d     <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ld_start) begin
                r_state <= S_LOAD;
                r_addr  <= '0;
                r_byte  <= '0;
                r_d     <= '0;
                r_valid <= 1'b0;
                r_ready <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (progress_ucode) begin
                            r_d <= r_mem[minx];
                        end
                    end
                    S_LOAD: begin
                        if (ld_valid) begin
                            r_asm[r_byte] <= ld_data;
                            if (r_byte == LAST_BYTE) begin
                                r_state <= S_WRITE;
                                r_ready <= 1'b0;
                            end else begin
                                r_byte <= r_byte + 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_byte <= '0;
                        if (r_addr == '1) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_LOAD;
                            r_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign d           = r_d;
    assign ucode_valid = r_valid;
    assign ld_ready    = r_ready;
    assign ld_busy     = r_busy;
    assign ld_done     = r_done;

endmodule

// File: tb/tb_m_ucode_store.sv
// Bench for m_ucode_store: small store (AW=2, DW=16) against a per-cycle behavioural
// model, plus a full load and random reads of the default-size store.
module tb_m_ucode_store;

    localparam int A_AW    = 2;
    localparam int A_DW    = 16;
    localparam int A_NB    = A_DW / 8;
    localparam int A_DEPTH = 1 << A_AW;
    localparam int B_AW    = 8;
    localparam int B_DW    = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [A_AW-1:0] a_minx;
    logic            a_prog;
    logic [A_DW-1:0] a_d;
    logic            a_uv, a_start, a_valid, a_ready, a_busy, a_done;
    logic [7:0]      a_data;

    logic [B_AW-1:0] b_minx;
    logic            b_prog;
    logic [B_DW-1:0] b_d;
    logic            b_uv, b_start, b_valid, b_ready, b_busy, b_done;
    logic [7:0]      b_data;

    m_ucode_store #(.AW(A_AW), .DW(A_DW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .minx(a_minx), .progress_ucode(a_prog), .d(a_d),
        .ucode_valid(a_uv), .ld_start(a_start), .ld_valid(a_valid), .ld_data(a_data),
        .ld_ready(a_ready), .ld_busy(a_busy), .ld_done(a_done)
    );

    m_ucode_store u_dut_b (
        .clk(clk), .rst_n(rst_n), .minx(b_minx), .progress_ucode(b_prog), .d(b_d),
        .ucode_valid(b_uv), .ld_start(b_start), .ld_valid(b_valid), .ld_data(b_data),
        .ld_ready(b_ready), .ld_busy(b_busy), .ld_done(b_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the small store: words, load progress, outputs.
    logic [A_DW-1:0] m_mem [A_DEPTH];
    logic [A_DW-1:0] m_word, m_d;
    bit              m_loading, m_wp, m_valid, m_done;
    int              m_nb, m_addr, m_acc;
    int              dut_done_cnt = 0;
    int              a_cycles = 0;

    task automatic model_reset();
        m_loading = 0; m_wp = 0; m_valid = 0; m_done = 0;
        m_nb = 0; m_addr = 0; m_acc = 0; m_d = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        a_cycles++;
        m_done = 0;
        if (a_start) begin
            m_loading = 1; m_wp = 0; m_nb = 0; m_addr = 0; m_acc = 0;
            m_valid = 0; m_d = '0;
        end else if (!m_loading) begin
            if (a_prog) m_d = m_mem[a_minx];
        end else if (m_wp) begin
            m_mem[m_addr] = m_word;
            m_wp = 0;
            if (m_addr == A_DEPTH - 1) begin
                m_loading = 0; m_valid = 1; m_done = 1;
            end else begin
                m_addr++;
            end
        end else if (a_valid) begin
            m_word[8*m_nb +: 8] = a_data;
            m_nb++;
            m_acc++;
            if (m_nb == A_NB) begin
                m_nb = 0;
                m_wp = 1;
            end
        end
        @(negedge clk);
        chk("d", a_d, m_d);
        chk("ucode_valid", a_uv, m_valid);
        chk("ld_ready", a_ready, m_loading && !m_wp);
        chk("ld_busy", a_busy, m_loading);
        chk("ld_done", a_done, m_done);
        if (a_done) dut_done_cnt++;
    endtask

    task automatic do_start();
        a_start = 1'b1;
        a_valid = 1'b0;
        tick();
        a_start = 1'b0;
    endtask

    task automatic stream(input logic [7:0] b[$], input int gap_pct);
        int budget = 40 * (b.size() + 2);
        while (m_acc < b.size() && budget > 0) begin
            a_valid = ($urandom_range(99) >= gap_pct);
            a_data  = a_valid ? b[m_acc] : 8'($urandom);
            tick();
            budget--;
        end
        a_valid = 1'b0;
        if (budget == 0) chk("stream_timeout", m_acc, b.size());
    endtask

    task automatic drain();
        int k = 0;
        while (m_loading && k < 10) begin
            tick();
            k++;
        end
        if (k == 10) chk("drain_timeout", m_loading, 0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_d", a_d, 0);
        chk("rst_uv", a_uv, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0]      pat1 [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    logic [7:0]      pat2 [8] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    logic [A_DW-1:0] exp1 [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    logic [A_DW-1:0] exp2 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        logic [7:0] q[$];
        logic [B_DW-1:0] b_exp;
        int cyc0, s, done_at, ndone;

        rst_n = 1'b0;
        a_minx = '0; a_prog = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = '0;
        b_minx = '0; b_prog = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_d", a_d, 0);
        chk("init_uv", a_uv, 0);
        chk("init_ready", a_ready, 0);
        chk("init_busy", a_busy, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back full load, then ordered reads.
        q.delete();
        foreach (pat1[i]) q.push_back(pat1[i]);
        cyc0 = a_cycles;
        s = dut_done_cnt;
        do_start();
        stream(q, 0);
        drain();
        chk("load_cycles", a_cycles - cyc0 - 1, 12);
        chk("done_pulses", dut_done_cnt - s, 1);
        chk("uv_after_load", a_uv, 1);
        a_prog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_minx = A_AW'(i);
            tick();
            chk("rd1", a_d, exp1[i]);
        end

        // Hold while progress_ucode is low.
        a_minx = 2'd0;
        tick();
        a_prog = 1'b0;
        a_minx = 2'd1;
        tick();
        a_minx = 2'd3;
        tick();
        chk("hold", a_d, 16'h1234);
        a_prog = 1'b1;
        tick();
        chk("release", a_d, 16'hDEF0);

        // Abort after five bytes, restart colliding with ld_valid, reads gated while busy.
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        do_start();
        stream(q, 20);
        s = dut_done_cnt;
        a_start = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'hFF;
        tick();
        a_start = 1'b0;
        a_valid = 1'b0;
        chk("abort_busy", a_busy, 1);
        a_prog = 1'b1;
        a_minx = 2'd2;
        q.delete();
        foreach (pat2[i]) q.push_back(pat2[i]);
        stream(q, 0);
        drain();
        chk("abort_done_pulses", dut_done_cnt - s, 1);
        a_prog = 1'b0;
        a_valid = 1'b1;
        a_data = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        a_valid = 1'b0;
        a_prog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_minx = A_AW'(i);
            tick();
            chk("rd2", a_d, exp2[i]);
        end

        // Random loads with gaps, random reads.
        for (int r = 0; r < 3; r++) begin
            q.delete();
            for (int i = 0; i < A_DEPTH * A_NB; i++) q.push_back(8'($urandom));
            a_prog = 1'($urandom);
            do_start();
            stream(q, 30);
            drain();
            a_prog = 1'b1;
            for (int i = 0; i < 8; i++) begin
                a_minx = A_AW'($urandom);
                a_prog = ($urandom_range(3) != 0);
                tick();
            end
        end

        // Asynchronous reset in IDLE, then mid-load; memory keeps written words.
        a_prog = 1'b1;
        a_minx = 2'd3;
        tick();
        async_reset();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        do_start();
        stream(q, 0);
        async_reset();
        for (int i = 0; i < 4; i++) begin
            a_minx = A_AW'(i);
            tick();
        end

        // Default-size store: 256 replicated words, continuous ld_valid.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_valid = 1'b1;
        done_at = -1;
        ndone = 0;
        for (int j = 0; j < 1800; j++) begin
            b_data = 8'(j / 7);
            @(negedge clk);
            if (b_done) begin
                ndone++;
                if (done_at < 0) done_at = j + 1;
            end
        end
        b_valid = 1'b0;
        chk("b_load_cycles", done_at, 1792);
        chk("b_done_pulses", ndone, 1);
        chk("b_uv", b_uv, 1);
        b_prog = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b_minx = B_AW'($urandom);
            b_exp = {6{b_minx}};
            @(negedge clk);
            chk("b_rd", b_d, b_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
